// File: rtl/mem_pkg.sv
// mem_pkg: byte-enable op encodings and lane width shared by the load/store units
package mem_pkg;
  localparam logic [1:0] BEOP_WORD = 2'b00;
  localparam logic [1:0] BEOP_HALF = 2'b01;
  localparam logic [1:0] BEOP_BYTE = 2'b10;
  localparam int BE_W = 4;
endpackage

// File: rtl/store_align.sv
// store_align: lane-replicates store data, builds byte enables and flags misaligned stores
module store_align
  import mem_pkg::*;
(
  input  logic [1:0]      addr_lo,
  input  logic [31:0]     data,
  input  logic [1:0]      beop,
  output logic [31:0]     wdata,
  output logic [BE_W-1:0] be,
  output logic            misaligned
);
  logic w_byte, w_half;
  assign w_byte = beop == BEOP_BYTE;
  assign w_half = beop == BEOP_HALF;
  // the reserved encoding falls through to word behaviour
  assign wdata = w_byte ? {4{data[7:0]}} : w_half ? {2{data[15:0]}} : data;
  assign be = w_byte ? 4'b0001 << addr_lo : w_half ? (addr_lo[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign misaligned = w_byte ? 1'b0 : w_half ? addr_lo[0] : addr_lo != 2'b00;
endmodule

// File: rtl/store_buffer_unit.sv
// store_buffer_unit: aligns M-stage stores, queues them in a small FIFO and drains
// them in order to data memory; reports misaligned stores and load/store word hazards.
module store_buffer_unit
  import mem_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int AW    = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            st_valid,
  input  logic [AW-1:0]   st_addr,
  input  logic [31:0]     st_data,
  input  logic [1:0]      BEOp,
  output logic            st_ready,
  input  logic            ld_check,
  input  logic [AW-1:0]   ld_addr,
  output logic            ld_hazard,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [31:0]     mem_wdata,
  output logic [BE_W-1:0] mem_be,
  input  logic            mem_ack,
  output logic            align_err,
  output logic [AW-1:0]   err_addr
);
  localparam int PW = $clog2(DEPTH);
  logic [AW-3:0]    r_addr [DEPTH];
  logic [31:0]      r_data [DEPTH];
  logic [BE_W-1:0]  r_be   [DEPTH];
  logic [DEPTH-1:0] r_vld;
  logic [PW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [PW:0]      r_count;
  logic             r_err;
  logic [AW-1:0]    r_err_addr;
  logic [31:0]      w_wdata;
  logic [BE_W-1:0]  w_be;
  logic             w_mis, w_enq, w_deq, w_hit;
  store_align u_align (
    .addr_lo   (st_addr[1:0]),
    .data      (st_data),
    .beop      (BEOp),
    .wdata     (w_wdata),
    .be        (w_be),
    .misaligned(w_mis)
  );
  assign st_ready  = r_count != (PW+1)'(DEPTH);
  assign mem_we    = r_count != '0;
  assign w_enq     = st_valid & st_ready & ~w_mis;
  assign w_deq     = mem_we & mem_ack;
  assign mem_addr  = {r_addr[r_rd_ptr], 2'b00};
  assign mem_wdata = r_data[r_rd_ptr];
  assign mem_be    = r_be[r_rd_ptr];
  assign align_err = r_err;
  assign err_addr  = r_err_addr;
  // every valid entry is compared, including the head being acked this cycle
  always_comb begin
    w_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      w_hit |= r_vld[i] && ((({r_addr[i], 2'b00} ^ ld_addr) & ~AW'(3)) == '0);
    ld_hazard = ld_check & w_hit;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_vld      <= '0;
      r_err      <= 1'b0;
      r_err_addr <= '0;
    end else begin
      r_err <= st_valid & w_mis;
      if (st_valid & w_mis) r_err_addr <= st_addr;
      r_count <= r_count + {{PW{1'b0}}, w_enq} - {{PW{1'b0}}, w_deq};
      if (w_deq) begin
        r_vld[r_rd_ptr] <= 1'b0;
        r_rd_ptr        <= r_rd_ptr + 1'b1;
      end
      if (w_enq) begin
        r_vld[r_wr_ptr] <= 1'b1;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_addr[r_wr_ptr] <= st_addr[AW-1:2];
      r_data[r_wr_ptr] <= w_wdata;
      r_be[r_wr_ptr]   <= w_be;
    end
  end
endmodule

// File: tb/tb_store_buffer_unit.sv
// tb_store_buffer_unit: directed checks of alignment, FIFO ordering, hazards and reset
module tb_store_buffer_unit;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        st_valid, ld_check, mem_ack;
  logic [31:0] st_addr, st_data, ld_addr;
  logic [1:0]  BEOp;
  logic        st_ready, ld_hazard, mem_we, align_err;
  logic [31:0] mem_addr, mem_wdata, err_addr;
  logic [3:0]  mem_be;
  int n_chk = 0;
  int n_fail = 0;

  store_buffer_unit #(.DEPTH(2), .AW(32)) dut (
    .clk(clk), .reset_n(reset_n), .st_valid(st_valid), .st_addr(st_addr),
    .st_data(st_data), .BEOp(BEOp), .st_ready(st_ready), .ld_check(ld_check),
    .ld_addr(ld_addr), .ld_hazard(ld_hazard), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ack(mem_ack),
    .align_err(align_err), .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [31:0] a, input logic [31:0] d, input logic [1:0] op);
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
    BEOp     = op;
  endtask

  initial begin
    reset_n = 1'b0; st_valid = 1'b0; st_addr = '0; st_data = '0; BEOp = 2'b00;
    ld_check = 1'b0; ld_addr = '0; mem_ack = 1'b0;
    #2;
    chk("rst_we", mem_we, 0);
    chk("rst_ready", st_ready, 1);
    chk("rst_err", align_err, 0);
    chk("rst_err_addr", err_addr, 0);
    step(); step();
    reset_n = 1'b1;
    step();

    // 1: byte store to lane 3, no bypass
    put(32'h0000_1003, 32'h1234_5604, 2'b10);
    #1 chk("t1_no_bypass", mem_we, 0);
    step(); st_valid = 1'b0; #1;
    chk("t1_we", mem_we, 1);
    chk("t1_addr", mem_addr, 32'h1000);
    chk("t1_wdata", mem_wdata, 32'h0404_0404);
    chk("t1_be", mem_be, 4'b1000);
    mem_ack = 1'b1; step(); mem_ack = 1'b0; #1;
    chk("t1_drained", mem_we, 0);

    // 2: halfword upper lanes, then misaligned halfword
    put(32'h2002, 32'hABCD_5604, 2'b01);
    step(); st_valid = 1'b0; #1;
    chk("t2_wdata", mem_wdata, 32'h5604_5604);
    chk("t2_be", mem_be, 4'b1100);
    mem_ack = 1'b1; step(); mem_ack = 1'b0;
    put(32'h2001, 32'hABCD_5604, 2'b01);
    step(); st_valid = 1'b0; #1;
    chk("t2_err", align_err, 1);
    chk("t2_err_addr", err_addr, 32'h2001);
    chk("t2_not_queued", mem_we, 0);
    step();
    chk("t2_err_pulse", align_err, 0);

    // 3: fill, hold third store, drain in order
    put(32'h4000, 32'h1111_1111, 2'b00); step();
    chk("t3_ready1", st_ready, 1);
    put(32'h4004, 32'h2222_2222, 2'b00); step();
    chk("t3_full", st_ready, 0);
    put(32'h4008, 32'h3333_3333, 2'b00); step();
    chk("t3_held", st_ready, 0);
    chk("t3_head0", mem_addr, 32'h4000);
    mem_ack = 1'b1; #1;
    chk("t3_no_comb_ready", st_ready, 0);
    step();
    chk("t3_head1", mem_addr, 32'h4004);
    chk("t3_data1", mem_wdata, 32'h2222_2222);
    chk("t3_ready_after_ack", st_ready, 1);
    step(); st_valid = 1'b0; #1;
    chk("t3_head2", mem_addr, 32'h4008);
    chk("t3_data2", mem_wdata, 32'h3333_3333);
    step(); mem_ack = 1'b0; #1;
    chk("t3_empty", mem_we, 0);

    // 4: steady enq+ack, pointers wrap
    put(32'h5000, 32'hA0, 2'b00); step();
    mem_ack = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      put(32'h5000 + 32'(4 * k), 32'hA0 + 32'(k), 2'b00);
      #1;
      chk("t4_head", mem_addr, 32'h5000 + 32'(4 * (k - 1)));
      chk("t4_data", mem_wdata, 32'hA0 + 32'(k - 1));
      step();
      chk("t4_ready", st_ready, 1);
    end
    st_valid = 1'b0; mem_ack = 1'b0; #1;
    chk("t4_last_addr", mem_addr, 32'h5020);
    chk("t4_last_data", mem_wdata, 32'hA8);
    mem_ack = 1'b1; step(); mem_ack = 1'b0; #1;
    chk("t4_empty", mem_we, 0);

    // 5: load hazard
    put(32'h3000, 32'hDEAD_BEEF, 2'b00); step(); st_valid = 1'b0;
    ld_check = 1'b1; ld_addr = 32'h3002; #1;
    chk("t5_hit", ld_hazard, 1);
    ld_addr = 32'h3004; #1;
    chk("t5_other_word", ld_hazard, 0);
    ld_addr = 32'h3000; mem_ack = 1'b1; #1;
    chk("t5_hit_during_ack", ld_hazard, 1);
    step(); mem_ack = 1'b0; #1;
    chk("t5_after_ack", ld_hazard, 0);
    ld_check = 1'b0;

    // 6: reset mid-drain
    put(32'h6000, 32'h6666_6666, 2'b00); step();
    put(32'h6004, 32'h7777_7777, 2'b00); step();
    st_valid = 1'b0; #1;
    chk("t6_pending", mem_we, 1);
    reset_n = 1'b0; #1;
    chk("t6_rst_we", mem_we, 0);
    chk("t6_rst_ready", st_ready, 1);
    chk("t6_rst_err", align_err, 0);
    step(); reset_n = 1'b1;
    step(); step();
    chk("t6_nothing_drains", mem_we, 0);
    ld_check = 1'b1; ld_addr = 32'h6000; #1;
    chk("t6_no_hazard", ld_hazard, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
